// File: rtl/local_history_update_queue.sv
// rtl/local_history_update_queue.sv - in-order queue of predicted branches driving local history table writes
module local_history_update_queue #(
    parameter int DEPTH      = 8,
    parameter int PC_WIDTH   = 32,
    parameter int HIST_WIDTH = 10,
    parameter int IDX_WIDTH  = 10
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       alloc_v_i,
    input  logic [PC_WIDTH-1:0]        alloc_pc_i,
    input  logic [HIST_WIDTH-1:0]      alloc_hist_i,
    input  logic                       alloc_pred_i,
    output logic                       alloc_ready_o,
    input  logic                       res_v_i,
    input  logic                       res_taken_i,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic [IDX_WIDTH-1:0]       w_idx_o,
    output logic                       taken_o,
    output logic                       correct_o,
    output logic [HIST_WIDTH-1:0]      hist_o,
    output logic                       mispredict_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] L_FULL = CNT_W'(DEPTH);

    // Entry storage: only the PC bits that form the table index are kept.
    logic [IDX_WIDTH-1:0]  r_idx_mem  [DEPTH];
    logic [HIST_WIDTH-1:0] r_hist_mem [DEPTH];
    logic                  r_pred_mem [DEPTH];

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  r_w_v;
    logic [IDX_WIDTH-1:0]  r_w_idx;
    logic [HIST_WIDTH-1:0] r_hist;
    logic                  r_taken;
    logic                  r_correct;
    logic                  r_mispredict;
    logic                  r_err;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_res_fire;
    logic                  w_alloc_fire;
    logic                  w_head_pred;
    logic                  w_mispred;
    logic                  w_squash;
    logic                  w_alloc_ok;
    logic                  w_err_evt;
    logic [PTR_W-1:0]      w_head_nxt;
    logic [PTR_W-1:0]      w_tail_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_unused_pc;

    // PC bits outside the index field carry no information for the table.
    assign w_unused_pc = ^{alloc_pc_i[PC_WIDTH-1:IDX_WIDTH+2], alloc_pc_i[1:0]};

    // Acceptance, retirement and squash decisions for this cycle.
    always_comb begin
        w_full       = (r_count == L_FULL);
        w_empty      = (r_count == '0);
        w_res_fire   = res_v_i && !w_empty;
        w_alloc_fire = alloc_v_i && !w_full;
        w_head_pred  = r_pred_mem[r_head];
        w_mispred    = w_res_fire && (res_taken_i != w_head_pred);
        // A wrong-path resolve or a flush wipes every entry younger than the retiree,
        // including anything fetch is trying to push in the same cycle.
        w_squash     = flush_i || w_mispred;
        w_alloc_ok   = w_alloc_fire && !w_squash;
        w_err_evt    = (alloc_v_i && w_full) || (res_v_i && w_empty);
        w_head_nxt   = r_head + PTR_W'(w_res_fire);
        if (w_squash) begin
            w_tail_nxt  = w_head_nxt;
            w_count_nxt = '0;
        end else begin
            w_tail_nxt  = r_tail + PTR_W'(w_alloc_ok);
            w_count_nxt = r_count + CNT_W'(w_alloc_ok) - CNT_W'(w_res_fire);
        end
    end

    // Capture the prediction record at the tail slot.
    always_ff @(posedge clk_i) begin
        if (w_alloc_ok) begin
            r_idx_mem[r_tail]  <= alloc_pc_i[IDX_WIDTH+1:2];
            r_hist_mem[r_tail] <= alloc_hist_i;
            r_pred_mem[r_tail] <= alloc_pred_i;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Registered history-table write; payload holds between writes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_w_v        <= 1'b0;
            r_w_idx      <= '0;
            r_hist       <= '0;
            r_taken      <= 1'b0;
            r_correct    <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_w_v        <= w_res_fire;
            r_mispredict <= w_mispred;
            if (w_res_fire) begin
                r_w_idx   <= r_idx_mem[r_head];
                r_hist    <= r_hist_mem[r_head];
                r_taken   <= res_taken_i;
                r_correct <= !w_mispred;
            end
        end
    end

    // Sticky protocol error: push into a full queue or resolve with nothing outstanding.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign alloc_ready_o = !w_full;
    assign count_o       = r_count;
    assign w_v_o         = r_w_v;
    assign w_idx_o       = r_w_idx;
    assign hist_o        = r_hist;
    assign taken_o       = r_taken;
    assign correct_o     = r_correct;
    assign mispredict_o  = r_mispredict;
    assign err_o         = r_err;

endmodule
